// File: rtl/i2s_clk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_clk_pkg : shared types and limits for the I2S clock scheduler.  Rev 1.0
// ---------------------------------------------------------------------------
package i2s_clk_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } sched_state_t;

   localparam int MIN_BCLK_DIV    = 2;
   localparam int MIN_HALF_BITS   = 1;
   localparam int DEF_BCLK_DIV_W  = 8;
   localparam int DEF_HALF_BITS_W = 7;

   typedef struct packed {
      logic [DEF_BCLK_DIV_W-1:0]  div;
      logic [DEF_HALF_BITS_W-1:0] half_bits;
   } clk_cfg_t;

   function automatic logic cfg_is_legal(input int div, input int half_bits);
      return (div >= MIN_BCLK_DIV) && (half_bits >= MIN_HALF_BITS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/phase_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phase_counter : modulo counter with runtime modulus and terminal-count flag.  Rev 1.0
// ---------------------------------------------------------------------------
module phase_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         load_zero,
   input  logic [W-1:0] modulus,
   output logic [W-1:0] count_next,
   output logic         tc
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign tc = (count_q == modulus - 1'b1);

   always_comb begin
      count_d = count_q;
      if (load_zero) begin
         count_d = '0;
      end else if (enable) begin
         count_d = tc ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Next value is exported so the parent can register outputs that line up with the count.
   assign count_next = count_d;

endmodule
`default_nettype wire

// File: rtl/i2s_clk_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_clk_scheduler : BCLK/LRCLK levels and edge strobes with frame-aligned reconfiguration.  Rev 1.0
// ---------------------------------------------------------------------------
module i2s_clk_scheduler
   import i2s_clk_pkg::*;
#(
   parameter int BCLK_DIV_W        = 8,
   parameter int HALF_BITS_W       = 7,
   parameter int DEFAULT_BCLK_DIV  = 4,
   parameter int DEFAULT_HALF_BITS = 32
) (
   input  logic                   clkIn,
   input  logic                   reset_n,
   input  logic                   run,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [BCLK_DIV_W-1:0]  cfg_bclk_div,
   input  logic [HALF_BITS_W-1:0] cfg_half_bits,
   output logic                   cfg_err,
   output logic                   bclk,
   output logic                   bclk_rise,
   output logic                   bclk_fall,
   output logic                   lrclk,
   output logic                   frame_start,
   output logic                   active
);

   sched_state_t state_q, state_d;

   logic [BCLK_DIV_W-1:0]  div_q, div_d, sh_div_q, sh_div_d;
   logic [HALF_BITS_W-1:0] hb_q, hb_d, sh_hb_q, sh_hb_d;
   logic pending_q, pending_d;
   logic lrclk_q, lrclk_d;
   logic cfg_ready_q, cfg_ready_d;
   logic cfg_err_q, cfg_err_d;
   logic bclk_q, bclk_d, bclk_rise_q, bclk_rise_d, bclk_fall_q, bclk_fall_d;
   logic frame_start_q, frame_start_d, active_q, active_d;

   logic                   running, div_tc, bit_tc, boundary;
   logic                   cfg_fire, cfg_legal, cfg_apply;
   logic [BCLK_DIV_W-1:0]  div_cnt_next;
   logic [HALF_BITS_W-1:0] bit_cnt_next;

   assign running   = (state_q != IDLE);
   assign boundary  = running && div_tc && bit_tc && lrclk_q;
   assign cfg_fire  = cfg_valid && cfg_ready_q;
   assign cfg_legal = cfg_is_legal(int'(cfg_bclk_div), int'(cfg_half_bits));
   assign cfg_apply = pending_q && (!running || boundary);

   phase_counter #(.W(BCLK_DIV_W)) u_div_cnt (
      .clk        (clkIn),
      .reset_n    (reset_n),
      .enable     (running),
      .load_zero  (!running),
      .modulus    (div_q),
      .count_next (div_cnt_next),
      .tc         (div_tc)
   );

   phase_counter #(.W(HALF_BITS_W)) u_bit_cnt (
      .clk        (clkIn),
      .reset_n    (reset_n),
      .enable     (running && div_tc),
      .load_zero  (!running),
      .modulus    (hb_q),
      .count_next (bit_cnt_next),
      .tc         (bit_tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (run) state_d = RUN;
         RUN:      if (!run) state_d = STOPPING;
         STOPPING: begin
            if (run) begin
               state_d = RUN;
            end else if (boundary) begin
               state_d = IDLE;
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   // A transfer in the applying cycle lands in the shadow and waits for the next boundary.
   always_comb begin
      div_d     = div_q;
      hb_d      = hb_q;
      sh_div_d  = sh_div_q;
      sh_hb_d   = sh_hb_q;
      pending_d = pending_q;
      if (cfg_apply) begin
         div_d     = sh_div_q;
         hb_d      = sh_hb_q;
         pending_d = 1'b0;
      end
      if (cfg_fire && cfg_legal) begin
         sh_div_d  = cfg_bclk_div;
         sh_hb_d   = cfg_half_bits;
         pending_d = 1'b1;
      end
      cfg_err_d   = cfg_fire && !cfg_legal;
      cfg_ready_d = (state_d == IDLE) || !pending_d;
   end

   always_comb begin
      lrclk_d = lrclk_q;
      if (!running) begin
         lrclk_d = 1'b0;
      end else if (div_tc && bit_tc) begin
         lrclk_d = !lrclk_q;
      end
      active_d      = (state_d != IDLE);
      bclk_d        = active_d && (div_cnt_next >= (div_d >> 1));
      bclk_rise_d   = active_d && (div_cnt_next == (div_d >> 1));
      bclk_fall_d   = active_d && (div_cnt_next == '0);
      frame_start_d = active_d && (div_cnt_next == '0) && (bit_cnt_next == '0) && !lrclk_d;
   end

   always_ff @(posedge clkIn) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         div_q         <= BCLK_DIV_W'(DEFAULT_BCLK_DIV);
         hb_q          <= HALF_BITS_W'(DEFAULT_HALF_BITS);
         sh_div_q      <= BCLK_DIV_W'(DEFAULT_BCLK_DIV);
         sh_hb_q       <= HALF_BITS_W'(DEFAULT_HALF_BITS);
         pending_q     <= 1'b0;
         lrclk_q       <= 1'b0;
         cfg_ready_q   <= 1'b0;
         cfg_err_q     <= 1'b0;
         bclk_q        <= 1'b0;
         bclk_rise_q   <= 1'b0;
         bclk_fall_q   <= 1'b0;
         frame_start_q <= 1'b0;
         active_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         hb_q          <= hb_d;
         sh_div_q      <= sh_div_d;
         sh_hb_q       <= sh_hb_d;
         pending_q     <= pending_d;
         lrclk_q       <= lrclk_d;
         cfg_ready_q   <= cfg_ready_d;
         cfg_err_q     <= cfg_err_d;
         bclk_q        <= bclk_d;
         bclk_rise_q   <= bclk_rise_d;
         bclk_fall_q   <= bclk_fall_d;
         frame_start_q <= frame_start_d;
         active_q      <= active_d;
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign cfg_err     = cfg_err_q;
   assign bclk        = bclk_q;
   assign bclk_rise   = bclk_rise_q;
   assign bclk_fall   = bclk_fall_q;
   assign lrclk       = lrclk_q;
   assign frame_start = frame_start_q;
   assign active      = active_q;

endmodule
`default_nettype wire
